pacman_motion_ctrl: RTL and testbench



---
 rtl/pacman_pkg.sv | 28 ++
 rtl/pacman_neighbor_tile.sv | 31 +++
 rtl/pacman_motion_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pacman_motion_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared definitions for the Pac-Man motion controller: maze geometry
// defaults, direction encoding and the FSM state type.
package pacman_pkg;

  localparam int DEF_TILE_W = 16;
  localparam int DEF_MAZE_W = 40;
  localparam int DEF_MAZE_H = 30;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK_TURN,
    ST_WAIT_T,
    ST_CHK_FWD,
    ST_WAIT_F,
    ST_MOVE
  } state_t;

  // Up/down and left/right pairs differ only in the low bit.
  function automatic logic [1:0] oppositeDir(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/pacman_neighbor_tile.sv
// Combinational neighbour-tile lookup with wrap-around at the maze edges,
// so the tunnel rows and columns connect to the opposite side.
module pacman_neighbor_tile
  import pacman_pkg::*;
#(
  parameter int MAZE_W = DEF_MAZE_W,
  parameter int MAZE_H = DEF_MAZE_H
) (
  input  logic [5:0] i_tx,
  input  logic [4:0] i_ty,
  input  logic [1:0] i_dir,
  output logic [5:0] o_tx,
  output logic [4:0] o_ty
);

  localparam logic [5:0] LAST_X = 6'(MAZE_W - 1);
  localparam logic [4:0] LAST_Y = 5'(MAZE_H - 1);

  // Step one tile in the requested direction, wrapping at either edge.
  always_comb begin
    o_tx = i_tx;
    o_ty = i_ty;
    case (i_dir)
      DIR_UP:   o_ty = (i_ty == 5'd0)  ? LAST_Y : i_ty - 5'd1;
      DIR_DOWN: o_ty = (i_ty == LAST_Y) ? 5'd0  : i_ty + 5'd1;
      DIR_LEFT: o_tx = (i_tx == 6'd0)  ? LAST_X : i_tx - 6'd1;
      default:  o_tx = (i_tx == LAST_X) ? 6'd0  : i_tx + 6'd1;
    endcase
  end

endmodule

// File: rtl/pacman_motion_ctrl.sv
// Per-frame Pac-Man position/direction controller. Latches the player's
// direction request, checks the wall ROM at tile boundaries and steps the
// sprite once per frame_tick.
module pacman_motion_ctrl
  import pacman_pkg::*;
#(
  parameter int TILE_W  = DEF_TILE_W,
  parameter int MAZE_W  = DEF_MAZE_W,
  parameter int MAZE_H  = DEF_MAZE_H,
  parameter int STEP    = 1,
  parameter int START_X = 304,
  parameter int START_Y = 368
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [3:0] btn_dir,
  output logic [5:0] wall_tx,
  output logic [4:0] wall_ty,
  output logic       wall_rd,
  input  logic       wall_q,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [1:0] dir,
  output logic       moving,
  output logic       busy
);

  localparam int         TSH    = $clog2(TILE_W);
  localparam logic [9:0] STEP10 = 10'(STEP);
  localparam logic [9:0] XLAST  = 10'(MAZE_W * TILE_W - STEP);
  localparam logic [9:0] YLAST  = 10'(MAZE_H * TILE_W - STEP);

  state_t     r_state, w_nextState;
  logic [9:0] r_posX, r_posY, w_stepX, w_stepY;
  logic [1:0] r_dir, r_reqDir, w_btnDir, w_queryDir;
  logic       r_reqValid, r_moving;
  logic [5:0] r_wallTx, w_curTx, w_nbTx;
  logic [4:0] r_wallTy, w_curTy, w_nbTy;
  logic       w_btnValid, w_aligned;
  logic       w_loadDir, w_clrReq, w_loadQuery, w_stop;

  assign w_curTx   = r_posX[TSH+5:TSH];
  assign w_curTy   = r_posY[TSH+4:TSH];
  assign w_aligned = (r_posX[TSH-1:0] == '0) && (r_posY[TSH-1:0] == '0);

  // Decode the button vector; anything other than exactly one bit is ignored.
  always_comb begin
    w_btnValid = 1'b1;
    w_btnDir   = DIR_LEFT;
    case (btn_dir)
      4'b1000: w_btnDir = DIR_UP;
      4'b0100: w_btnDir = DIR_DOWN;
      4'b0010: w_btnDir = DIR_LEFT;
      4'b0001: w_btnDir = DIR_RIGHT;
      default: w_btnValid = 1'b0;
    endcase
  end

  // Next-state logic plus the strobes that update direction, request and query address.
  always_comb begin
    w_nextState = r_state;
    w_loadDir   = 1'b0;
    w_clrReq    = 1'b0;
    w_loadQuery = 1'b0;
    w_stop      = 1'b0;
    w_queryDir  = r_dir;
    case (r_state)
      ST_IDLE: begin
        if (frame_tick) begin
          if (r_reqValid && (r_reqDir == oppositeDir(r_dir))) begin
            w_loadDir   = 1'b1;
            w_clrReq    = 1'b1;
            w_nextState = ST_MOVE;
          end else begin
            if (r_reqValid && (r_reqDir == r_dir))
              w_clrReq = 1'b1;
            if (w_aligned && r_reqValid && (r_reqDir != r_dir)) begin
              w_queryDir  = r_reqDir;
              w_loadQuery = 1'b1;
              w_nextState = ST_CHK_TURN;
            end else if (w_aligned) begin
              w_loadQuery = 1'b1;
              w_nextState = ST_CHK_FWD;
            end else begin
              w_nextState = ST_MOVE;
            end
          end
        end
      end
      ST_CHK_TURN: w_nextState = ST_WAIT_T;
      ST_WAIT_T: begin
        if (!wall_q) begin
          w_loadDir   = 1'b1;
          w_clrReq    = 1'b1;
          w_nextState = ST_MOVE;
        end else begin
          w_loadQuery = 1'b1;
          w_nextState = ST_CHK_FWD;
        end
      end
      ST_CHK_FWD: w_nextState = ST_WAIT_F;
      ST_WAIT_F: begin
        if (!wall_q) begin
          w_nextState = ST_MOVE;
        end else begin
          w_stop      = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      ST_MOVE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  pacman_neighbor_tile #(
    .MAZE_W(MAZE_W),
    .MAZE_H(MAZE_H)
  ) u_neighbor (
    .i_tx (w_curTx),
    .i_ty (w_curTy),
    .i_dir(w_queryDir),
    .o_tx (w_nbTx),
    .o_ty (w_nbTy)
  );

  // One-step position update with pixel wrap for the tunnels.
  always_comb begin
    w_stepX = r_posX;
    w_stepY = r_posY;
    case (r_dir)
      DIR_UP:   w_stepY = (r_posY == 10'd0)  ? YLAST : r_posY - STEP10;
      DIR_DOWN: w_stepY = (r_posY >= YLAST)  ? 10'd0 : r_posY + STEP10;
      DIR_LEFT: w_stepX = (r_posX == 10'd0)  ? XLAST : r_posX - STEP10;
      default:  w_stepX = (r_posX >= XLAST)  ? 10'd0 : r_posX + STEP10;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  // Datapath registers: request latch, direction, query address, position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reqDir   <= DIR_LEFT;
      r_reqValid <= 1'b0;
      r_dir      <= DIR_LEFT;
      r_wallTx   <= '0;
      r_wallTy   <= '0;
      r_posX     <= 10'(START_X);
      r_posY     <= 10'(START_Y);
      r_moving   <= 1'b0;
    end else begin
      if (w_btnValid) begin
        r_reqDir   <= w_btnDir;
        r_reqValid <= 1'b1;
      end else if (w_clrReq) begin
        r_reqValid <= 1'b0;
      end
      if (w_loadDir)
        r_dir <= r_reqDir;
      if (w_loadQuery) begin
        r_wallTx <= w_nbTx;
        r_wallTy <= w_nbTy;
      end
      if (r_state == ST_MOVE) begin
        r_posX   <= w_stepX;
        r_posY   <= w_stepY;
        r_moving <= 1'b1;
      end else if (w_stop) begin
        r_moving <= 1'b0;
      end
    end
  end

  assign wall_rd = (r_state == ST_CHK_TURN) || (r_state == ST_CHK_FWD);
  assign wall_tx = r_wallTx;
  assign wall_ty = r_wallTy;
  assign pos_x   = r_posX;
  assign pos_y   = r_posY;
  assign dir     = r_dir;
  assign moving  = r_moving;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// Self-checking bench for pacman_motion_ctrl. A frame-level reference model
// predicts position, direction, wall queries and latency for every tick.
module tb_pacman_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] btn_dir = 4'b0000;
  logic       wall_q = 1'b0;
  logic [5:0] wall_tx;
  logic [4:0] wall_ty;
  logic       wall_rd;
  logic [9:0] pos_x, pos_y;
  logic [1:0] dir;
  logic       moving, busy;

  int vectors = 0;
  int miscompares = 0;

  logic mapW [0:39][0:29];
  int   qTx[$];
  int   qTy[$];

  int mX, mY, mDir, mRd;
  bit mRv, mMov;
  int expEdges, expQn;
  int expTx[2];
  int expTy[2];

  always #5 clk = ~clk;

  pacman_motion_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .btn_dir   (btn_dir),
    .wall_tx   (wall_tx),
    .wall_ty   (wall_ty),
    .wall_rd   (wall_rd),
    .wall_q    (wall_q),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .dir       (dir),
    .moving    (moving),
    .busy      (busy)
  );

  // Registered wall ROM; outside a read the data line carries noise.
  always @(posedge clk) begin
    if (wall_rd) begin
      qTx.push_back(int'(wall_tx));
      qTy.push_back(int'(wall_ty));
      wall_q <= (wall_tx < 6'd40 && wall_ty < 5'd30) ? mapW[wall_tx][wall_ty] : 1'b1;
    end else begin
      wall_q <= 1'($urandom_range(0, 1));
    end
  end

  function automatic int oppOf(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic clearMap();
    for (int x = 0; x < 40; x++)
      for (int y = 0; y < 30; y++)
        mapW[x][y] = 1'b0;
  endtask

  task automatic modelStep();
    case (mDir)
      0: mY = (mY + 479) % 480;
      1: mY = (mY + 1) % 480;
      2: mX = (mX + 639) % 640;
      default: mX = (mX + 1) % 640;
    endcase
    mMov = 1'b1;
  endtask

  task automatic modelQuery(input int d, output bit blocked);
    int tx, ty;
    tx = mX / 16;
    ty = mY / 16;
    case (d)
      0: ty = (ty + 29) % 30;
      1: ty = (ty + 1) % 30;
      2: tx = (tx + 39) % 40;
      default: tx = (tx + 1) % 40;
    endcase
    expTx[expQn] = tx;
    expTy[expQn] = ty;
    expQn++;
    blocked = mapW[tx][ty];
  endtask

  // What one frame should do, derived from the movement rules directly.
  task automatic modelFrame();
    bit blocked, turned;
    expQn = 0;
    turned = 1'b0;
    if (mRv && mRd == oppOf(mDir)) begin
      mDir = mRd;
      mRv = 1'b0;
      modelStep();
      expEdges = 2;
    end else begin
      if (mRv && mRd == mDir) mRv = 1'b0;
      if ((mX % 16) != 0 || (mY % 16) != 0) begin
        modelStep();
        expEdges = 2;
      end else begin
        expEdges = 0;
        if (mRv) begin
          modelQuery(mRd, blocked);
          expEdges = 2;
          if (!blocked) begin
            mDir = mRd;
            mRv = 1'b0;
            modelStep();
            expEdges = 4;
            turned = 1'b1;
          end
        end
        if (!turned) begin
          modelQuery(mDir, blocked);
          if (!blocked) begin
            modelStep();
            expEdges += 4;
          end else begin
            mMov = 1'b0;
            expEdges += 3;
          end
        end
      end
    end
  endtask

  task automatic doReset();
    btn_dir = 4'b0000;
    frame_tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mX = 304; mY = 368; mDir = 2; mRd = 2; mRv = 1'b0; mMov = 1'b0;
    qTx.delete();
    qTy.delete();
  endtask

  task automatic press(input int d);
    @(negedge clk);
    btn_dir = 4'b1000 >> d;
    @(negedge clk);
    btn_dir = 4'b0000;
    mRv = 1'b1;
    mRd = d;
  endtask

  task automatic junkButton();
    logic [3:0] b;
    b = 4'($urandom_range(0, 15));
    if ($countones(b) == 1) b = 4'b0000;
    @(negedge clk);
    btn_dir = b;
    @(negedge clk);
    btn_dir = 4'b0000;
  endtask

  // One frame: tick, wait for IDLE (bounded), compare everything to the model.
  task automatic runFrame(input bit inject, input string tag);
    int edges;
    modelFrame();
    qTx.delete();
    qTy.delete();
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    edges = 1;
    if (inject && busy) frame_tick = 1'b1;
    while (busy && edges < 20) begin
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      edges++;
    end
    frame_tick = 1'b0;
    vectors++;
    if (edges !== expEdges) begin
      miscompares++;
      $display("[TB] FAIL %s latency: got %0d edges, expected %0d", tag, edges, expEdges);
    end
    vectors++;
    if (pos_x !== 10'(mX) || pos_y !== 10'(mY)) begin
      miscompares++;
      $display("[TB] FAIL %s pos: got (%0d,%0d), expected (%0d,%0d)", tag, pos_x, pos_y, mX, mY);
    end
    vectors++;
    if (dir !== 2'(mDir) || moving !== mMov) begin
      miscompares++;
      $display("[TB] FAIL %s dir/moving: got %0d/%0d, expected %0d/%0d", tag, dir, moving, mDir, mMov);
    end
    vectors++;
    if (qTx.size() != expQn) begin
      miscompares++;
      $display("[TB] FAIL %s wall reads: got %0d, expected %0d", tag, qTx.size(), expQn);
    end else begin
      for (int i = 0; i < expQn; i++) begin
        vectors++;
        if (qTx[i] != expTx[i] || qTy[i] != expTy[i]) begin
          miscompares++;
          $display("[TB] FAIL %s query%0d: got (%0d,%0d), expected (%0d,%0d)",
                   tag, i, qTx[i], qTy[i], expTx[i], expTy[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (pos_x !== 10'd304 || pos_y !== 10'd368) begin
      miscompares++;
      $display("[TB] FAIL reset pos: got (%0d,%0d), expected (304,368)", pos_x, pos_y);
    end
    vectors++;
    if (dir !== 2'd2 || moving !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset dir/moving/busy: got %0d/%0d/%0d, expected 2/0/0", dir, moving, busy);
    end
    vectors++;
    if (wall_rd !== 1'b0 || wall_tx !== 6'd0 || wall_ty !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL reset wall port: got rd=%0d (%0d,%0d), expected rd=0 (0,0)", wall_rd, wall_tx, wall_ty);
    end
    doReset();
    // Abort mid-query: wall_rd must fall without waiting for a clock edge.
    @(negedge clk);
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    vectors++;
    if (wall_rd !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset setup: got rd=%0d busy=%0d, expected 1/1", wall_rd, busy);
    end
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (wall_rd !== 1'b0 || busy !== 1'b0 || pos_x !== 10'd304) begin
      miscompares++;
      $display("[TB] FAIL midreset abort: got rd=%0d busy=%0d x=%0d, expected 0/0/304", wall_rd, busy, pos_x);
    end
    doReset();
  endtask

  task automatic test_blocked_forward();
    doReset();
    clearMap();
    mapW[18][23] = 1'b1;
    runFrame(1'b0, "blocked_fwd");
    mapW[18][23] = 1'b0;
  endtask

  task automatic test_turn();
    doReset();
    clearMap();
    press(0);
    runFrame(1'b0, "turn_ok");
    doReset();
    mapW[19][22] = 1'b1;
    press(0);
    runFrame(1'b0, "turn_rejected");
    mapW[19][22] = 1'b0;
    runFrame(1'b0, "turn_retry");
  endtask

  task automatic test_forward();
    doReset();
    clearMap();
    for (int i = 0; i < 3; i++) runFrame(1'b0, "forward");
  endtask

  task automatic test_reversal();
    press(3);
    runFrame(1'b0, "reversal");
    vectors++;
    if (pos_x !== 10'd302 || dir !== 2'd3) begin
      miscompares++;
      $display("[TB] FAIL reversal abs: got x=%0d dir=%0d, expected x=302 dir=3", pos_x, dir);
    end
  endtask

  task automatic test_invalid_btn();
    for (int i = 0; i < 4; i++) junkButton();
    runFrame(1'b0, "invalid_btn");
  endtask

  task automatic test_tunnel();
    int guard;
    doReset();
    clearMap();
    press(0);
    guard = 0;
    while (mY != 224 && guard < 400) begin
      runFrame(1'b0, "climb");
      guard++;
    end
    press(2);
    guard = 0;
    while (mX != 0 && guard < 400) begin
      runFrame(1'b0, "run_left");
      guard++;
    end
    runFrame(1'b1, "tunnel");
    vectors++;
    if (pos_x !== 10'd639 || pos_y !== 10'd224) begin
      miscompares++;
      $display("[TB] FAIL tunnel abs: got (%0d,%0d), expected (639,224)", pos_x, pos_y);
    end
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (pos_x !== 10'd639 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL busy_tick ignored: got x=%0d busy=%0d, expected 639/0", pos_x, busy);
    end
  endtask

  task automatic test_random();
    int r;
    doReset();
    for (int x = 0; x < 40; x++)
      for (int y = 0; y < 30; y++)
        mapW[x][y] = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 5);
      if (r < 2)       press($urandom_range(0, 3));
      else if (r == 2) junkButton();
      else             runFrame(1'b0, "random");
    end
  endtask

  initial begin
    clearMap();
    test_reset();
    test_blocked_forward();
    test_turn();
    test_forward();
    test_reversal();
    test_invalid_btn();
    test_tunnel();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
